// File: rtl/instr_mem_loader_if.sv
// Load-session handshake plus byte-write bus between a word source and the instruction memory loader.
// The loader side uses the slave modport; the word source / memory side uses master.
interface instr_mem_loader_if;
    logic        start;
    logic [63:0] base_addr;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_last;
    logic        word_ready;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  word_count;

    modport slave (
        input  start, base_addr, word_valid, word_data, word_last,
        output word_ready, mem_we, mem_addr, mem_wdata, busy, done, error, word_count
    );

    modport master (
        output start, base_addr, word_valid, word_data, word_last,
        input  word_ready, mem_we, mem_addr, mem_wdata, busy, done, error, word_count
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Splits 32-bit instruction words into big-endian byte writes: 4 write cycles per accepted word, so 1 word / 5 cycles.
// Backpressure: word_ready is high only in LOAD, so words offered while writing or idle are left unconsumed.
module instr_mem_loader #(
    parameter int unsigned MEM_BYTES = 264
) (
    input  logic             clk,
    input  logic             reset,
    instr_mem_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERR} state_t;

    // 65-bit capacity so that ptr+4 cannot wrap past the comparison
    localparam logic [64:0] CAP = 65'(MEM_BYTES);

    state_t      state_q, state_d;
    logic [63:0] ptr_q,   ptr_d;
    logic [1:0]  beat_q,  beat_d;
    logic [31:0] word_q,  word_d;
    logic        last_q,  last_d;
    logic [7:0]  cnt_q,   cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            beat_q  <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            word_q  <= word_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        word_d  = word_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (bus.start) begin
                    if (bus.base_addr[1:0] != 2'b00) begin
                        state_d = ERR;
                    end else begin
                        ptr_d   = bus.base_addr;
                        cnt_d   = '0;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (bus.word_valid) begin
                    word_d = bus.word_data;
                    last_d = bus.word_last;
                    // Capacity is checked at acceptance so no byte of an oversized word is ever written
                    if (({1'b0, ptr_q} + 65'd4) <= CAP) begin
                        beat_d  = 2'd0;
                        state_d = WRITE;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            WRITE: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    ptr_d   = ptr_q + 64'd4;
                    cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    state_d = last_q ? DONE : LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic [7:0] byte_sel;
    always_comb begin
        byte_sel = 8'h00;
        case (beat_q)
            2'd0: byte_sel = word_q[31:24];
            2'd1: byte_sel = word_q[23:16];
            2'd2: byte_sel = word_q[15:8];
            2'd3: byte_sel = word_q[7:0];
            default: byte_sel = 8'h00;
        endcase
    end

    assign bus.word_ready = (state_q == LOAD);
    assign bus.mem_we     = (state_q == WRITE);
    assign bus.mem_addr   = (state_q == WRITE) ? (ptr_q + {62'd0, beat_q}) : 64'd0;
    assign bus.mem_wdata  = (state_q == WRITE) ? byte_sel : 8'h00;
    assign bus.busy       = (state_q == LOAD) || (state_q == WRITE);
    assign bus.done       = (state_q == DONE);
    assign bus.error      = (state_q == ERR);
    assign bus.word_count = cnt_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: inputs driven and outputs sampled on the falling edge.
module tb_instr_mem_loader;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   wr_cnt;
    int   snap;

    instr_mem_loader_if bus ();

    instr_mem_loader #(.MEM_BYTES(264)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.mem_we === 1'b1) wr_cnt++;

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge while the DUT sits in LOAD; returns on the falling edge of beat 3.
    task automatic write_word(input logic [31:0] data, input logic last, input logic [63:0] addr);
        chk1("ready_before_word", bus.word_ready, 1'b1);
        bus.word_valid = 1'b1;
        bus.word_data  = data;
        bus.word_last  = last;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) bus.word_valid = 1'b0;
            chk1("beat_we", bus.mem_we, 1'b1);
            chk64("beat_addr", bus.mem_addr, addr + 64'(k));
            chk8("beat_data", bus.mem_wdata, data[31-8*k -: 8]);
            chk1("beat_ready_low", bus.word_ready, 1'b0);
        end
    endtask

    task automatic start_session(input logic [63:0] base);
        bus.start     = 1'b1;
        bus.base_addr = base;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        wr_cnt = 0;
        reset  = 1'b1;
        bus.start      = 1'b0;
        bus.base_addr  = 64'd0;
        bus.word_valid = 1'b0;
        bus.word_data  = 32'd0;
        bus.word_last  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk1("rst_ready", bus.word_ready, 1'b0);
        chk1("rst_we", bus.mem_we, 1'b0);
        chk64("rst_addr", bus.mem_addr, 64'd0);
        chk8("rst_wdata", bus.mem_wdata, 8'h00);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_done", bus.done, 1'b0);
        chk1("rst_error", bus.error, 1'b0);
        chk8("rst_count", bus.word_count, 8'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk1("idle_busy", bus.busy, 1'b0);
        chk1("idle_ready", bus.word_ready, 1'b0);

        // Basic single word
        start_session(64'd0);
        chk1("basic_busy", bus.busy, 1'b1);
        write_word(32'h01400513, 1'b1, 64'd0);
        @(negedge clk);
        chk1("basic_done", bus.done, 1'b1);
        chk8("basic_count", bus.word_count, 8'd1);
        chk1("basic_busy_end", bus.busy, 1'b0);
        chk1("basic_we_end", bus.mem_we, 1'b0);

        // Two-word stream; ready must return at N+5
        start_session(64'd8);
        chk1("stream_done_cleared", bus.done, 1'b0);
        write_word(32'h00400593, 1'b0, 64'd8);
        @(negedge clk);
        write_word(32'h00500293, 1'b1, 64'd12);
        @(negedge clk);
        chk1("stream_done", bus.done, 1'b1);
        chk8("stream_count", bus.word_count, 8'd2);

        // Misaligned start from DONE
        start_session(64'd6);
        chk1("mis_error", bus.error, 1'b1);
        chk1("mis_done", bus.done, 1'b0);
        chk1("mis_busy", bus.busy, 1'b0);
        bus.word_valid = 1'b1;
        bus.word_data  = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            chk1("mis_ready", bus.word_ready, 1'b0);
            chk1("mis_we", bus.mem_we, 1'b0);
            @(negedge clk);
        end
        bus.word_valid = 1'b0;

        // Overflow: 260..263 fits, next word does not
        start_session(64'd260);
        chk1("ovf_error_cleared", bus.error, 1'b0);
        chk1("ovf_busy", bus.busy, 1'b1);
        write_word(32'h11223344, 1'b0, 64'd260);
        @(negedge clk);
        chk1("ovf_ready2", bus.word_ready, 1'b1);
        bus.word_valid = 1'b1;
        bus.word_data  = 32'h55667788;
        bus.word_last  = 1'b1;
        @(negedge clk);
        bus.word_valid = 1'b0;
        chk1("ovf_we", bus.mem_we, 1'b0);
        chk1("ovf_error", bus.error, 1'b1);
        chk8("ovf_count", bus.word_count, 8'd1);
        chk1("ovf_ready", bus.word_ready, 1'b0);
        @(negedge clk);
        chk1("ovf_we_later", bus.mem_we, 1'b0);

        // Reset after beat 1: only two bytes land
        start_session(64'h20);
        snap = wr_cnt;
        bus.word_valid = 1'b1;
        bus.word_data  = 32'hAABBCCDD;
        bus.word_last  = 1'b1;
        @(negedge clk);
        bus.word_valid = 1'b0;
        chk8("rmw_b0", bus.mem_wdata, 8'hAA);
        @(negedge clk);
        chk64("rmw_b1_addr", bus.mem_addr, 64'h21);
        #2 reset = 1'b1;
        #1;
        chk1("rmw_we", bus.mem_we, 1'b0);
        chk64("rmw_addr", bus.mem_addr, 64'd0);
        chk8("rmw_wdata", bus.mem_wdata, 8'h00);
        chk1("rmw_busy", bus.busy, 1'b0);
        chk8("rmw_count", bus.word_count, 8'd0);
        repeat (2) @(negedge clk);
        chk1("rmw_we_held", bus.mem_we, 1'b0);
        chk64("rmw_bytes", 64'(wr_cnt - snap), 64'd2);
        reset = 1'b0;
        @(negedge clk);
        chk1("rmw_idle", bus.busy, 1'b0);
        start_session(64'h40);
        write_word(32'h01020304, 1'b1, 64'h40);
        @(negedge clk);
        chk1("rmw_new_done", bus.done, 1'b1);
        chk8("rmw_new_count", bus.word_count, 8'd1);

        // Start pulse while busy is ignored
        start_session(64'h80);
        bus.start     = 1'b1;
        bus.base_addr = 64'd100;
        @(negedge clk);
        bus.start     = 1'b0;
        chk1("sb_busy", bus.busy, 1'b1);
        write_word(32'hDEADBEEF, 1'b0, 64'h80);
        @(negedge clk);
        write_word(32'hCAFEF00D, 1'b1, 64'h84);
        @(negedge clk);
        chk1("sb_done", bus.done, 1'b1);
        chk8("sb_count", bus.word_count, 8'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
